mult_div_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage, with the architectural HI/LO registers. It consumes the forwarded rs and rt operands produced by the EX-stage forwarding muxes and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Its HI/LO outputs feed the MFHI/MFLO result path. The busy output drives the hazard unit's stall logic.

---
 rtl/mult_div_unit_if.sv | 26 ++
 rtl/mult_div_unit.sv | 159 +++++++++++++++
 tb/tb_mult_div_unit.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between the EX-stage operand muxes and the
// iterative multiply/divide unit. The master side drives requests; the unit
// (slave) returns the architectural HI/LO values and its busy/done status.
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             flush;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;

   modport master (
      output start, op, rs_val, rt_val, flush,
      input  hi, lo, busy, done
   );

   modport slave (
      input  start, op, rs_val, rt_val, flush,
      output hi, lo, busy, done
   );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// MULT/MULTU use a radix-2 shift-add over operand magnitudes, DIV/DIVU use
// restoring division; signs are re-applied in a single FIX cycle. MTHI/MTLO
// write HI/LO directly from IDLE with one-edge latency.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            rst_n,
   mult_div_unit_if.slave bus
);
   localparam int                 CW        = $clog2(WIDTH);
   localparam logic [CW-1:0]      LAST_ITER = CW'(WIDTH - 1);
   localparam logic [2:0]         OP_MTHI   = 3'd4;
   localparam logic [2:0]         OP_MTLO   = 3'd5;
   localparam logic [WIDTH-1:0]   ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0] ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]   ALL_ONES  = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   // Two's-complement negate when requested; used for magnitudes and sign fix.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic neg);
      return neg ? ((~v) + ONE_W) : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                        input logic neg);
      return neg ? ((~v) + ONE_2W) : v;
   endfunction

   state_t                  state, state_nxt;
   logic [CW-1:0]           iter_cnt;
   logic [WIDTH-1:0]        hi_q, lo_q;
   logic                    done_q;

   // Operand / iteration datapath (not reset: only meaningful after accept)
   logic                    is_div, sign_a, sign_b, div_zero;
   logic [WIDTH-1:0]        acc_hi, acc_lo, opnd_m, rs_raw;

   logic signed [WIDTH-1:0] rs_s, rt_s;
   logic                    accept, rs_neg, rt_neg;
   logic [WIDTH:0]          mul_sum, div_trial;
   logic [WIDTH-1:0]        step_hi, step_lo;
   logic [2*WIDTH-1:0]      prod_fix;
   logic [WIDTH-1:0]        quo_fix, rem_fix;

   assign rs_s   = bus.rs_val;
   assign rt_s   = bus.rt_val;
   // op 0..3 are the iterative ops; op[0]=1 selects the unsigned variant.
   assign accept = (state == IDLE) && bus.start && !bus.op[2];
   assign rs_neg = !bus.op[0] && (rs_s < 0);
   assign rt_neg = !bus.op[0] && (rt_s < 0);

   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
   assign bus.busy = (state == CALC) || (state == FIX);
   assign bus.done = done_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; flush always wins over finishing the operation.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = CALC;
         CALC:    if (bus.flush) state_nxt = IDLE;
                  else if (iter_cnt == LAST_ITER) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One multiply or divide step on the magnitude registers.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_m} : '0);
      div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opnd_m};
      if (is_div) begin
         // Restoring step: keep the difference only if it did not borrow.
         step_hi = div_trial[WIDTH] ? {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]}
                                    : div_trial[WIDTH-1:0];
         step_lo = {acc_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      end else begin
         // Shift-add: partial product in acc_hi, multiplier drains from acc_lo.
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // Sign fix applied to the finished magnitudes.
   always_comb begin
      prod_fix = cond_neg_wide({acc_hi, acc_lo}, sign_a ^ sign_b);
      quo_fix  = cond_neg(acc_lo, sign_a ^ sign_b);
      rem_fix  = cond_neg(acc_hi, sign_a);
   end

   // Operand capture on accept, then one iteration per CALC cycle.
   always_ff @(posedge clk) begin
      if (accept) begin
         is_div   <= bus.op[1];
         sign_a   <= rs_neg;
         sign_b   <= rt_neg;
         div_zero <= bus.op[1] && (bus.rt_val == '0);
         rs_raw   <= bus.rs_val;
         acc_hi   <= '0;
         acc_lo   <= cond_neg(bus.rs_val, rs_neg);
         opnd_m   <= cond_neg(bus.rt_val, rt_neg);
      end else if (state == CALC) begin
         acc_hi   <= step_hi;
         acc_lo   <= step_lo;
      end
   end

   // Architectural HI/LO, iteration counter and the done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         iter_cnt <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               iter_cnt <= '0;
               if (bus.start && bus.op == OP_MTHI) hi_q <= bus.rs_val;
               if (bus.start && bus.op == OP_MTLO) lo_q <= bus.rs_val;
            end
            CALC: begin
               if (!bus.flush) iter_cnt <= iter_cnt + 1'b1;
            end
            FIX: begin
               if (!bus.flush) begin
                  done_q <= 1'b1;
                  if (div_zero) begin
                     hi_q <= rs_raw;
                     lo_q <= ALL_ONES;
                  end else if (is_div) begin
                     hi_q <= rem_fix;
                     lo_q <= quo_fix;
                  end else begin
                     {hi_q, lo_q} <= prod_fix;
                  end
               end
            end
            default: iter_cnt <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: MTHI/MTLO, signed/unsigned multiply and
// divide, divide-by-zero, flush in CALC/FIX/IDLE, start while busy,
// back-to-back issue and asynchronous reset in the middle of an operation.
module tb_mult_div_unit;
   localparam int W = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   tests_run    = 0;
   int   tests_failed = 0;
   int   done_seen    = 0;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Present a request for exactly one clock edge, then return to no-op.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
      bus.start  = 1'b1;
      bus.op     = op;
      bus.rs_val = rs;
      bus.rt_val = rt;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.op     = 3'd7;
      bus.rs_val = '0;
      bus.rt_val = '0;
   endtask

   // Advance n edges, counting done pulses seen 1ns after each edge.
   task automatic wait_edges(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (bus.done === 1'b1) done_seen++;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.op = 3'd7; bus.rs_val = '0; bus.rt_val = '0; bus.flush = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, expected all zero",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_mthi_mtlo();
      issue(3'd4, 32'hAAAA0000, 32'h0);
      tests_run++;
      if ({bus.hi, bus.busy, bus.done} !== {32'hAAAA0000, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL mthi: hi=%h busy=%b done=%b, expected hi=aaaa0000 busy=0 done=0",
                  bus.hi, bus.busy, bus.done);
      end
      issue(3'd5, 32'h00005555, 32'h0);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'hAAAA0000, 32'h00005555, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b, expected aaaa0000/00005555 busy=0 done=0",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      issue(3'd6, 32'h12345678, 32'h9);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy} !== {32'hAAAA0000, 32'h00005555, 1'b0}) begin
         tests_failed++;
         $display("FAIL noop: hi=%h lo=%h busy=%b, expected aaaa0000/00005555 busy=0",
                  bus.hi, bus.lo, bus.busy);
      end
   endtask

   task automatic test_mult();
      done_seen = 0;
      issue(3'd0, 32'hFFFFFFFD, 32'h5);
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL mult_busy_e0: busy=%b, expected 1", bus.busy);
      end
      wait_edges(32);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'hAAAA0000, 32'h00005555, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL mult_e32: hi=%h lo=%h busy=%b done=%b, expected aaaa0000/00005555 busy=1 done=0",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      wait_edges(1);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL mult_neg: hi=%h lo=%h busy=%b done=%b, expected ffffffff/fffffff1 busy=0 done=1",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      wait_edges(2);
      tests_run++;
      if (done_seen !== 1) begin
         tests_failed++;
         $display("FAIL mult_done_count: got %0d pulses, expected 1", done_seen);
      end
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_edges(33);
      tests_run++;
      if ({bus.hi, bus.lo, bus.done} !== {32'hFFFFFFFE, 32'h00000001, 1'b1}) begin
         tests_failed++;
         $display("FAIL multu_max: hi=%h lo=%h done=%b, expected fffffffe/00000001 done=1",
                  bus.hi, bus.lo, bus.done);
      end
   endtask

   task automatic test_div();
      issue(3'd2, 32'hFFFFFFF9, 32'h2);
      wait_edges(33);
      tests_run++;
      if ({bus.hi, bus.lo, bus.done} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1}) begin
         tests_failed++;
         $display("FAIL div_neg_dividend: hi=%h lo=%h done=%b, expected ffffffff/fffffffd done=1",
                  bus.hi, bus.lo, bus.done);
      end
      issue(3'd2, 32'h00000007, 32'hFFFFFFFE);
      wait_edges(33);
      tests_run++;
      if ({bus.hi, bus.lo} !== {32'h00000001, 32'hFFFFFFFD}) begin
         tests_failed++;
         $display("FAIL div_neg_divisor: hi=%h lo=%h, expected 00000001/fffffffd", bus.hi, bus.lo);
      end
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
      wait_edges(33);
      tests_run++;
      if ({bus.hi, bus.lo} !== {32'h00000000, 32'h80000000}) begin
         tests_failed++;
         $display("FAIL div_overflow: hi=%h lo=%h, expected 00000000/80000000", bus.hi, bus.lo);
      end
   endtask

   task automatic test_div_by_zero();
      issue(3'd3, 32'h00001234, 32'h0);
      wait_edges(32);
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL divz_latency: busy=%b at E32, expected 1", bus.busy);
      end
      wait_edges(1);
      tests_run++;
      if ({bus.hi, bus.lo, bus.done} !== {32'h00001234, 32'hFFFFFFFF, 1'b1}) begin
         tests_failed++;
         $display("FAIL divu_zero: hi=%h lo=%h done=%b, expected 00001234/ffffffff done=1",
                  bus.hi, bus.lo, bus.done);
      end
      issue(3'd2, 32'hFFFFFFF0, 32'h0);
      wait_edges(33);
      tests_run++;
      if ({bus.hi, bus.lo} !== {32'hFFFFFFF0, 32'hFFFFFFFF}) begin
         tests_failed++;
         $display("FAIL div_zero_signed: hi=%h lo=%h, expected fffffff0/ffffffff", bus.hi, bus.lo);
      end
   endtask

   task automatic test_flush();
      done_seen = 0;
      issue(3'd2, 32'd100, 32'd7);
      wait_edges(20);
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL flush_busy_e20: busy=%b, expected 1", bus.busy);
      end
      bus.flush = 1'b1;
      wait_edges(1);
      bus.flush = 1'b0;
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL flush_calc_busy: busy=%b after E21, expected 0", bus.busy);
      end
      wait_edges(14);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, done_seen} !== {32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 32'd0}) begin
         tests_failed++;
         $display("FAIL flush_calc_keep: hi=%h lo=%h busy=%b dones=%0d, expected fffffff0/ffffffff busy=0 dones=0",
                  bus.hi, bus.lo, bus.busy, done_seen);
      end
      issue(3'd1, 32'd3, 32'd4);
      wait_edges(32);
      bus.flush = 1'b1;
      wait_edges(1);
      bus.flush = 1'b0;
      wait_edges(2);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, done_seen} !== {32'hFFFFFFF0, 32'hFFFFFFFF, 1'b0, 32'd0}) begin
         tests_failed++;
         $display("FAIL flush_fix: hi=%h lo=%h busy=%b dones=%0d, expected fffffff0/ffffffff busy=0 dones=0",
                  bus.hi, bus.lo, bus.busy, done_seen);
      end
      bus.flush = 1'b1;
      issue(3'd4, 32'h0BADF00D, 32'h0);
      bus.flush = 1'b0;
      tests_run++;
      if (bus.hi !== 32'h0BADF00D) begin
         tests_failed++;
         $display("FAIL flush_idle_start: hi=%h, expected 0badf00d", bus.hi);
      end
   endtask

   task automatic test_start_while_busy();
      done_seen = 0;
      issue(3'd3, 32'd100, 32'd7);
      wait_edges(4);
      issue(3'd0, 32'd9, 32'd9);
      issue(3'd5, 32'h0000DEAD, 32'h0);
      wait_edges(26);
      tests_run++;
      if ({bus.lo, bus.busy} !== {32'hFFFFFFFF, 1'b1}) begin
         tests_failed++;
         $display("FAIL busy_mtlo_ignored: lo=%h busy=%b, expected ffffffff busy=1", bus.lo, bus.busy);
      end
      wait_edges(1);
      tests_run++;
      if ({bus.hi, bus.lo, bus.done} !== {32'h00000002, 32'h0000000E, 1'b1}) begin
         tests_failed++;
         $display("FAIL busy_start_result: hi=%h lo=%h done=%b, expected 00000002/0000000e done=1",
                  bus.hi, bus.lo, bus.done);
      end
      wait_edges(3);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, done_seen} !== {32'h00000002, 32'h0000000E, 1'b0, 32'd1}) begin
         tests_failed++;
         $display("FAIL busy_no_queue: hi=%h lo=%h busy=%b dones=%0d, expected 00000002/0000000e busy=0 dones=1",
                  bus.hi, bus.lo, bus.busy, done_seen);
      end
   endtask

   task automatic test_back_to_back();
      issue(3'd1, 32'd3, 32'd4);
      wait_edges(33);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'h0, 32'd12, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL b2b_first: hi=%h lo=%h busy=%b done=%b, expected 00000000/0000000c busy=0 done=1",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      issue(3'd3, 32'd12, 32'd5);
      tests_run++;
      if (bus.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_accept_e34: busy=%b, expected 1", bus.busy);
      end
      wait_edges(33);
      tests_run++;
      if ({bus.hi, bus.lo, bus.done} !== {32'd2, 32'd2, 1'b1}) begin
         tests_failed++;
         $display("FAIL b2b_second: hi=%h lo=%h done=%b, expected 00000002/00000002 done=1",
                  bus.hi, bus.lo, bus.done);
      end
   endtask

   task automatic test_reset_mid_op();
      done_seen = 0;
      issue(3'd0, 32'd5, 32'd7);
      wait_edges(9);
      tests_run++;
      if ({bus.hi, bus.busy} !== {32'd2, 1'b1}) begin
         tests_failed++;
         $display("FAIL rst_mid_pre: hi=%h busy=%b, expected 00000002 busy=1", bus.hi, bus.busy);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'h0, 32'h0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL rst_mid_async: hi=%h lo=%h busy=%b done=%b, expected all zero",
                  bus.hi, bus.lo, bus.busy, bus.done);
      end
      #2;
      rst_n = 1'b1;
      wait_edges(35);
      tests_run++;
      if ({bus.hi, bus.lo, bus.busy, done_seen} !== {32'h0, 32'h0, 1'b0, 32'd0}) begin
         tests_failed++;
         $display("FAIL rst_mid_after: hi=%h lo=%h busy=%b dones=%0d, expected zero, busy=0, dones=0",
                  bus.hi, bus.lo, bus.busy, done_seen);
      end
   endtask

   initial begin
      test_reset();
      test_mthi_mtlo();
      test_mult();
      test_div();
      test_div_by_zero();
      test_flush();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_op();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
